// File: rtl/draw_cmd_decoder.sv
// draw_cmd_decoder: buffers 32-bit draw commands, expands point/rect into
// logical-grid cell writes and pairs 0x9/0xa words for the line/text engine.
// Optional build macro DRAW_CMD_ERR_CNT_EN enables the saturating decode
// error counter on err_cnt; without it err_cnt is tied to zero.
module draw_cmd_decoder #(
  parameter int                       FIFO_DEPTH     = 16,
  parameter int                       H_LOGIC_WIDTH  = 5,
  parameter int                       V_LOGIC_WIDTH  = 5,
  parameter logic [H_LOGIC_WIDTH-1:0] H_LOGIC_MAX    = 5'd31,
  parameter logic [V_LOGIC_WIDTH-1:0] V_LOGIC_MAX    = 5'd23,
  parameter int                       COLOR_ID_WIDTH = 8,
  parameter int                       CMD_WIDTH      = 32
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [CMD_WIDTH-1:0]                   cmd,
  input  logic                                   cmd_vld,
  output logic                                   fb_we,
  output logic [V_LOGIC_WIDTH+H_LOGIC_WIDTH-1:0] fb_addr,
  output logic [COLOR_ID_WIDTH-1:0]              fb_data,
  output logic [2*CMD_WIDTH-1:0]                 ext_cmd,
  output logic                                   ext_vld,
  input  logic                                   ext_rdy,
  output logic                                   busy,
  output logic                                   ovf,
  output logic [7:0]                             err_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] DECODE  = 3'd1;
  localparam logic [2:0] FILL    = 3'd2;
  localparam logic [2:0] PAIR    = 3'd3;
  localparam logic [2:0] EXT_OUT = 3'd4;

  localparam logic [3:0] OP_POINT = 4'h0;
  localparam logic [3:0] OP_RECT  = 4'h1;
  localparam logic [3:0] OP_LINE  = 4'h9;
  localparam logic [3:0] OP_CHAR  = 4'ha;

  logic [CMD_WIDTH-1:0]      r_mem [FIFO_DEPTH];
  logic [AW:0]               r_wptr;
  logic [AW:0]               r_rptr;
  logic                      r_ovf;
  logic [2:0]                r_state;
  logic [CMD_WIDTH-1:0]      r_word;
  logic [CMD_WIDTH-1:0]      r_hold;
  logic [2*CMD_WIDTH-1:0]    r_ext;
  logic [H_LOGIC_WIDTH-1:0]  r_x;
  logic [H_LOGIC_WIDTH-1:0]  r_x0;
  logic [H_LOGIC_WIDTH-1:0]  r_x1;
  logic [V_LOGIC_WIDTH-1:0]  r_y;
  logic [V_LOGIC_WIDTH-1:0]  r_y1;
  logic [COLOR_ID_WIDTH-1:0] r_col;

  logic                      w_empty;
  logic                      w_full;
  logic                      w_pop;
  logic                      w_push;
  logic [CMD_WIDTH-1:0]      w_head;
  logic [3:0]                w_op;
  logic [H_LOGIC_WIDTH-1:0]  w_x0;
  logic [V_LOGIC_WIDTH-1:0]  w_y0;
  logic [H_LOGIC_WIDTH-1:0]  w_rx1;
  logic [V_LOGIC_WIDTH-1:0]  w_ry1;
  logic [H_LOGIC_WIDTH-1:0]  w_cx1;
  logic [V_LOGIC_WIDTH-1:0]  w_cy1;
  logic [COLOR_ID_WIDTH-1:0] w_pcol;
  logic [COLOR_ID_WIDTH-1:0] w_rcol;
  logic                      w_is_pt;
  logic                      w_is_ext;
  logic                      w_dec_err;
  logic                      w_pair_ok;
  logic                      w_err;

  // FIFO status; the extra pointer bit separates full from empty
  assign w_empty = r_wptr == r_rptr;
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_head  = r_mem[r_rptr[AW-1:0]];
  assign w_pop   = !w_empty && (r_state == IDLE || r_state == PAIR);
  assign w_push  = cmd_vld && (!w_full || w_pop);

  // Field extraction; point and rect share the x0/y0 bit positions
  assign w_op   = r_word[31:28];
  assign w_x0   = r_word[27:23];
  assign w_y0   = r_word[22:18];
  assign w_pcol = r_word[17:10];
  assign w_rx1  = r_word[17:13];
  assign w_ry1  = r_word[12:8];
  assign w_rcol = r_word[7:0];

  // Clamp rect corners to the grid; compare one bit wider so the check never folds to a constant
  assign w_cx1 = ({1'b0, w_rx1} > {1'b0, H_LOGIC_MAX}) ? H_LOGIC_MAX : w_rx1;
  assign w_cy1 = ({1'b0, w_ry1} > {1'b0, V_LOGIC_MAX}) ? V_LOGIC_MAX : w_ry1;

  assign w_is_pt  = w_op == OP_POINT;
  assign w_is_ext = w_op == OP_LINE || w_op == OP_CHAR;

  // Decode-time errors: off-grid point, empty rect, orphan word1, unknown opcode
  assign w_dec_err = w_is_pt ? (({1'b0, w_x0} > {1'b0, H_LOGIC_MAX}) || ({1'b0, w_y0} > {1'b0, V_LOGIC_MAX}))
                   : (w_op == OP_RECT) ? (w_x0 > w_cx1 || w_y0 > w_cy1)
                   : w_is_ext ? r_word[0]
                   : 1'b1;

  assign w_pair_ok = (w_head[31:28] == r_hold[31:28]) && w_head[0];

  assign w_err = (r_state == DECODE && w_dec_err) || (r_state == PAIR && !w_empty && !w_pair_ok);

  assign fb_we   = r_state == FILL;
  assign fb_addr = fb_we ? {r_y, r_x} : '0;
  assign fb_data = fb_we ? r_col : '0;
  assign ext_vld = r_state == EXT_OUT;
  assign ext_cmd = r_ext;
  assign busy    = !w_empty || r_state != IDLE;
  assign ovf     = r_ovf;

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= cmd;
  end

  // FIFO pointers and the sticky overflow flag for words dropped while full
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (cmd_vld && !w_push) r_ovf <= 1'b1;
    end
  end

  // Command FSM: fetch, decode, raster fill and two-word pairing with output handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_word  <= '0;
      r_hold  <= '0;
      r_ext   <= '0;
      r_x     <= '0;
      r_x0    <= '0;
      r_x1    <= '0;
      r_y     <= '0;
      r_y1    <= '0;
      r_col   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_word  <= w_head;
            r_state <= DECODE;
          end
        end
        DECODE: begin
          if (w_dec_err) begin
            r_state <= IDLE;
          end else if (w_is_ext) begin
            r_hold  <= r_word;
            r_state <= PAIR;
          end else begin
            r_x     <= w_x0;
            r_x0    <= w_x0;
            r_y     <= w_y0;
            r_x1    <= w_is_pt ? w_x0 : w_cx1;
            r_y1    <= w_is_pt ? w_y0 : w_cy1;
            r_col   <= w_is_pt ? w_pcol : w_rcol;
            r_state <= FILL;
          end
        end
        FILL: begin
          if (r_x == r_x1) begin
            r_x <= r_x0;
            if (r_y == r_y1) r_state <= IDLE;
            else r_y <= r_y + 1'b1;
          end else begin
            r_x <= r_x + 1'b1;
          end
        end
        PAIR: begin
          if (!w_empty) begin
            if (w_pair_ok) begin
              r_ext   <= {r_hold, w_head};
              r_state <= EXT_OUT;
            end else begin
              r_word  <= w_head;
              r_state <= DECODE;
            end
          end
        end
        EXT_OUT: begin
          if (ext_rdy) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef DRAW_CMD_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  // Saturating count of decode errors, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_err_cnt <= 8'h00;
    else if (w_err && r_err_cnt != 8'hff) r_err_cnt <= r_err_cnt + 8'd1;
  end

  assign err_cnt = r_err_cnt;
`else
  logic w_err_unused;
  assign w_err_unused = w_err;
  assign err_cnt = 8'h00;
`endif

endmodule

// File: doc/draw_cmd_decoder.md
Name: draw_cmd_decoder

Overview:
Consumer end of the 32-bit draw-command stream (cmd/cmd_vld) produced by the game cores. Buffers commands in a small FIFO and executes logical-grid commands (point, rectangle fill) as cell writes into the logical framebuffer. Two-word physical commands (line, char) are paired into a single 64-bit word and handed to the line/text engine over a valid/ready handshake. Sits between snake_core (or any cmd producer) and the VGA framebuffer/text engines.

Parameters:
FIFO_DEPTH, 16, command FIFO entries (power of 2)
H_LOGIC_WIDTH, 5, logical x width
V_LOGIC_WIDTH, 5, logical y width
H_LOGIC_MAX, 5'd31, last logical column
V_LOGIC_MAX, 5'd23, last logical row
COLOR_ID_WIDTH, 8, colour id width
CMD_WIDTH, 32, command word width

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low
cmd  input  32  draw command word
cmd_vld  input  1  cmd valid, one word per cycle, no backpressure
fb_we  output  1  framebuffer write strobe
fb_addr  output  10  cell address {y[4:0], x[4:0]}
fb_data  output  8  colour id
ext_cmd  output  64  {word0, word1} of a paired 0x9/0xa command
ext_vld  output  1  ext_cmd valid
ext_rdy  input  1  line/text engine ready
busy  output  1  FIFO non-empty or FSM not IDLE
ovf  output  1  sticky: a word arrived while FIFO full
err_cnt  output  8  decode error count (see Optional Feature)

Behaviour:
- Reset (rst=0, async): all outputs 0, FIFO empty, FSM IDLE, ovf 0, held word cleared.
- FIFO: push on cmd_vld if not full; push while full -> word dropped, ovf set until reset. Simultaneous push+pop when full is allowed (no drop).
- Opcode = cmd[31:28]. Field layouts:
  0x0 point: x=[27:23], y=[22:18], colour=[17:10].
  0x1 rect: x0=[27:23], y0=[22:18], x1=[17:13], y1=[12:8], colour=[7:0].
  0x9/0xa: two words; word0 has bit0=0, word1 has bit0=1, same opcode.
  Any other opcode: dropped, counted as decode error.
- FSM states: IDLE, DECODE, FILL, PAIR, EXT_OUT.
  IDLE: FIFO non-empty -> pop, DECODE next cycle.
  DECODE: 0x0 -> single write (x,y), FILL; 0x1 -> FILL; 0x9/0xa bit0=0 -> store word0, PAIR; 0x9/0xa bit0=1 with nothing held -> error, IDLE; other -> error, IDLE.
  FILL: one fb_we per cycle, x inner loop x0..x1, y outer y0..y1; x1, y1 clamped to H_LOGIC_MAX/V_LOGIC_MAX; x0>x1 or y0>y1 after clamp -> zero writes, error. After the last write -> IDLE.
  PAIR: wait for the next FIFO word; same opcode and bit0=1 -> EXT_OUT with ext_cmd={word0,word1}. Anything else -> held word discarded, error, new word re-decoded as in DECODE (no loss).
  EXT_OUT: ext_vld=1, ext_cmd stable until ext_rdy=1 in the same cycle; then IDLE.
- Latency: word on cmd at cycle N (FIFO empty, IDLE) -> pop N+1 -> DECODE N+2 -> first fb_we N+3.
- Full clear (0..31 x 0..23) = 768 fb_we cycles; a 10-word burst behind it must fit in the FIFO.
- Address = {y, x}; x,y out of range on point (x>31 impossible, y>23) -> no write, error.

Optional Feature:
DRAW_CMD_ERR_CNT_EN: when defined, err_cnt increments by 1 on every decode error (bad opcode, orphan word1, broken pair, empty rect, point y out of range), saturating at 8'hff, cleared only by reset. When undefined, err_cnt is tied to 8'h00 and no counter logic is built.

Test Plan:
- Point {0x0, x=3, y=5, colour 0x0f} at cycle N -> exactly one fb_we at N+3, fb_addr=10'h0A3, fb_data=0x0f; busy low at N+4.
- Clear {0x1,0,0,31,23,0xff} followed by 9 back-to-back words -> 768 writes covering addresses 0..0x2FF (row 23 top), then the queued words execute in order; ovf=0.
- Line pair {0x9,639,442,0x02,1'b0} then {…,1'b1} with ext_rdy low for 5 cycles -> ext_vld held, ext_cmd stable, ext_cmd[0]=1 and ext_cmd[32]=0; drops 1 cycle after ext_rdy=1.
- Char word0 (0xa) followed by a point word -> held word discarded, err_cnt=1 (macro on), point still written.
- Rect x0=10, x1=4 -> no fb_we, err_cnt increments; rect y1=30 -> rows clamped to 23.
- 17 words pushed during a clear with FIFO_DEPTH=16 -> ovf=1; rst low mid-fill -> fb_we=0 immediately, FIFO empty, ovf=0.
